depth_event_arbiter: RTL and testbench
======================================

# depth_event_arbiter

Round-robin arbiter that merges up to N_SRC independent 256-bit event-record streams (e.g. per-symbol or per-side depth parsers) onto the single event bus feeding the order-book stage. Each winning record is captured in a one-entry output register tagged with its source index; fairness is strict round-robin with no starvation. Optional per-source grant and back-pressure counters support bring-up and latency analysis.

## Interface
- N_SRC, 4: number of requesting streams, 2..8
- DATA_W, 256: record bus width; carries `event_record_t` in bits [224:0], upper bits passed through unmodified
- SRC_W, $clog2(N_SRC): source-tag width (derived, not overridden)

- clk  in  1  single clock domain
- rst  in  1  synchronous, active-high reset
- s_valid  in  N_SRC  per-source record valid
- s_ready  out  N_SRC  per-source accept; one-hot or zero
- s_data  in  N_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W]
- m_valid  out  1  output record valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  granted record
- m_src  out  SRC_W  index of the source that produced m_data
- stats_clr  in  1  zeroes all counters (stats build only)
- grant_cnt  out  N_SRC*32  per-source accepted-record counts
- stall_cnt  out  32  cycles with m_valid=1 and m_ready=0

## Operation
- Output slot is free when m_valid=0 or m_ready=1.
- When the slot is free, the arbiter grants the first asserted s_valid searching from (last_grant+1) mod N_SRC upward with wrap; s_ready[g]=1 for that source only, that cycle.
- s_ready is combinational from s_valid, m_valid, m_ready and last_grant; all s_ready are 0 when the slot is not free.
- A transfer on source g occurs when s_valid[g] & s_ready[g]; then m_data<=s_data[g], m_src<=g, m_valid<=1, last_grant<=g.
- Slot free with no s_valid: m_valid<=0; last_grant unchanged.
- m_data/m_src hold stable while m_valid=1 and m_ready=0.
- Records are not inspected or modified; no ordering across sources is enforced.
- Sources must hold s_valid/s_data until accepted; arbiter never drops or duplicates a record.

## Timing
- Reset values: m_valid=0, m_data=0, m_src=0, last_grant=N_SRC-1 (source 0 has first priority), all counters 0.
- Latency: s_valid&s_ready at cycle t -> m_valid=1 at t+1.
- Throughput: one record per cycle sustained when m_ready=1 continuously.
- Back-to-back: with all sources valid and m_ready=1, grants cycle 0,1,2,3,0,...
- Simultaneous m_ready and new grant in same cycle: current record retires, new one loads; no bubble.
- rst asserted mid-transfer: output register and pointer return to reset values next edge; pending record discarded; s_ready=0 during rst.
- Any source waits at most N_SRC-1 grants after becoming valid.

## Configuration
- DEPTH_EVENT_ARB_STATS_EN defined: grant_cnt[i] increments on each transfer from source i; stall_cnt increments each cycle m_valid & !m_ready; both 32-bit wrap at 2^32-1 -> 0; stats_clr (synchronous) zeroes all counters, taking priority over increments in the same cycle.
- Undefined: counter registers not instantiated; grant_cnt and stall_cnt tied to 0; stats_clr ignored.

## Structure
- Shared package `event_record_types`: `event_record_t`, plus new constants EVENT_BUS_W=256 and ARB_CNT_W=32.
- One sub-module natural: `rr_pick` — combinational round-robin priority picker (request vector + last_grant -> one-hot grant + index).

## Test plan
- Reset: hold rst 3 cycles with all s_valid=1 -> s_ready=0, m_valid=0, m_src=0 throughout; first grant after release is source 0.
- Fairness: all 4 sources valid, m_ready=1 for 8 cycles -> m_src sequence 0,1,2,3,0,1,2,3, one record per cycle.
- Sparse: only sources 1 and 3 valid -> m_src alternates 1,3,1,3; sources 0,2 never receive s_ready.
- Back-pressure: m_ready=0 for 5 cycles with m_valid=1 -> m_data/m_src stable, all s_ready=0, stall_cnt +5 (stats build).
- Wrap/priority: last_grant=3, sources 0 and 2 valid -> source 0 granted next, then 2.
- Stats: 10 grants to source 2 then stats_clr coincident with a grant -> grant_cnt[2]=0 after the edge; without macro all counters read 0.

Source files
------------

// File: rtl/event_record_types.sv
// rtl/event_record_types.sv - shared event-record types and bus constants
//
// Purpose: record layout carried on the depth event bus, plus the bus and
// counter widths shared by the arbiter, its interface and its sub-modules.
// Ports: none (package).

package event_record_types;

  localparam int EVENT_BUS_W = 256;
  localparam int ARB_CNT_W   = 32;

  // Occupies bits [224:0] of an EVENT_BUS_W word; upper bits are free for
  // producers and are passed through untouched.
  typedef struct packed {
    logic [15:0] seq;
    logic [63:0] ts_ns;
    logic [31:0] symbol_id;
    logic [63:0] price;
    logic [31:0] qty;
    logic [7:0]  level;
    logic [7:0]  action;
    logic        side;
  } event_record_t;

  localparam int EVENT_RECORD_W = $bits(event_record_t);

endpackage

// File: rtl/depth_event_arbiter_if.sv
// rtl/depth_event_arbiter_if.sv - source/sink handshake bundle for the arbiter
//
// Purpose: groups the N_SRC source streams and the single merged output
// stream into one bundle.
// Signals: s_valid/s_ready/s_data (per-source, source i at
// [i*DATA_W +: DATA_W]), m_valid/m_ready/m_data/m_src (merged output).
// Modports: slave  - arbiter side (consumes sources, drives output)
//           master - environment side (drives sources, consumes output)

interface depth_event_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = event_record_types::EVENT_BUS_W
);

  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]        s_valid;
  logic [N_SRC-1:0]        s_ready;
  logic [N_SRC*DATA_W-1:0] s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [DATA_W-1:0]       m_data;
  logic [SRC_W-1:0]        m_src;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_src
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_src
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
//
// Purpose: given a request vector and the last granted index, grants the
// first requester found searching upward from last_grant+1 with wrap.
// Ports: req        in  N_SRC  request vector
//        last_grant in  SRC_W  index granted most recently
//        gnt        out N_SRC  one-hot grant (zero when no request)
//        gnt_idx    out SRC_W  index of the granted requester
//        gnt_any    out 1      a grant was issued

module rr_pick #(
  parameter  int N_SRC = 4,
  localparam int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] last_grant,
  output logic [N_SRC-1:0] gnt,
  output logic [SRC_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int               cand;
  logic [SRC_W-1:0] cand_idx;

  // Walk N_SRC candidates starting just past last_grant; the first hit wins.
  // Modulo arithmetic keeps non-power-of-two N_SRC correct.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand     = (int'(last_grant) + k) % N_SRC;
      cand_idx = SRC_W'(cand);
      if (!gnt_any && req[cand_idx]) begin
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
        gnt_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/depth_event_arbiter.sv
// rtl/depth_event_arbiter.sv - round-robin merge of N_SRC event streams
//
// Purpose: merges N_SRC record streams onto one output bus through a
// one-entry output register tagged with the source index. Strict
// round-robin, source 0 first after reset.
// Ports: clk        in   clock
//        rst        in   synchronous active-high reset
//        bus        slave  s_valid/s_ready/s_data in, m_valid/m_ready/
//                          m_data/m_src out
//        stats_clr  in   zeroes all counters (stats build only)
//        grant_cnt  out  N_SRC x 32 per-source accepted-record counts
//        stall_cnt  out  cycles with m_valid=1 and m_ready=0
// Build option: DEPTH_EVENT_ARB_STATS_EN enables the counters; otherwise
// grant_cnt/stall_cnt read 0 and stats_clr is ignored.

module depth_event_arbiter #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = event_record_types::EVENT_BUS_W
) (
  input  logic                                          clk,
  input  logic                                          rst,
  depth_event_arbiter_if.slave                          bus,
  input  logic                                          stats_clr,
  output logic [N_SRC*event_record_types::ARB_CNT_W-1:0] grant_cnt,
  output logic [event_record_types::ARB_CNT_W-1:0]       stall_cnt
);

  import event_record_types::*;

  localparam int SRC_W = $clog2(N_SRC);

  logic             slot_free;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] gnt;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_any;

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [SRC_W-1:0]  m_src_q, m_src_d;
  logic [SRC_W-1:0]  last_grant_q, last_grant_d;

  // The slot can take a new record when empty or when the current one
  // retires this cycle, so a steady m_ready gives one record per cycle.
  assign slot_free = !m_valid_q || bus.m_ready;

  // Masking requests (rather than the grant) keeps s_ready at zero during
  // reset and while the slot is occupied.
  assign req = (!rst && slot_free) ? bus.s_valid : '0;

  rr_pick #(.N_SRC(N_SRC)) u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign bus.s_ready = gnt;

  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_src_d      = m_src_q;
    last_grant_d = last_grant_q;
    if (gnt_any) begin
      m_valid_d    = 1'b1;
      m_src_d      = gnt_idx;
      last_grant_d = gnt_idx;
      for (int i = 0; i < N_SRC; i++) begin
        if (gnt[i]) begin
          m_data_d = bus.s_data[i*DATA_W +: DATA_W];
        end
      end
    end else if (slot_free) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_src_q      <= '0;
      last_grant_q <= SRC_W'(N_SRC - 1);
    end else begin
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_src_q      <= m_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_src   = m_src_q;

`ifdef DEPTH_EVENT_ARB_STATS_EN
  logic [ARB_CNT_W-1:0] grant_cnt_q [N_SRC];
  logic [ARB_CNT_W-1:0] grant_cnt_d [N_SRC];
  logic [ARB_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counters wrap naturally; a clear wins over an increment in the same cycle.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
    end
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      for (int i = 0; i < N_SRC; i++) begin
        grant_cnt_d[i] = '0;
      end
      stall_cnt_d = '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (gnt[i]) begin
          grant_cnt_d[i] = grant_cnt_q[i] + ARB_CNT_W'(1);
        end
      end
      if (m_valid_q && !bus.m_ready) begin
        stall_cnt_d = stall_cnt_q + ARB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        grant_cnt_q[i] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        grant_cnt_q[i] <= grant_cnt_d[i];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_cnt_out
    assign grant_cnt[g*ARB_CNT_W +: ARB_CNT_W] = grant_cnt_q[g];
  end
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign grant_cnt        = '0;
  assign stall_cnt        = '0;
`endif

endmodule

// File: tb/tb_depth_event_arbiter.sv
// tb/tb_depth_event_arbiter.sv - self-checking bench for depth_event_arbiter

module tb_depth_event_arbiter;

  localparam int N  = 4;
  localparam int W  = 256;
  localparam int SW = 2;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            stats_clr = 1'b0;
  logic [N*CW-1:0] grant_cnt;
  logic [CW-1:0]   stall_cnt;

  depth_event_arbiter_if #(.N_SRC(N), .DATA_W(W)) bus ();

  depth_event_arbiter #(.N_SRC(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: output slot, pointer, counters, and source-side state.
  logic          mv = 1'b0;
  logic [W-1:0]  md = '0;
  int            ms = 0;
  int            ml = N - 1;
  logic [CW-1:0] eg [N];
  logic [CW-1:0] es = '0;
  logic [W-1:0]  src_data [N];
  logic [N-1:0]  vld = '0;
  bit            rand_src = 1'b0;
  int            waits [N];

  function automatic logic [W-1:0] rand_rec();
    logic [W-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Winner = valid source at the smallest circular distance past the last
  // grant; -1 when the slot is busy, in reset, or nothing is valid.
  function automatic int pick();
    int best;
    int bd;
    int d;
    if (rst || (mv && !bus.m_ready)) return -1;
    best = -1;
    bd = N;
    for (int i = 0; i < N; i++) begin
      if (vld[i]) begin
        d = (i - ml - 1 + 2 * N) % N;
        if (d < bd) begin
          bd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] onehot(int w);
    logic [N-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [N*CW-1:0] exp_gcnt();
    logic [N*CW-1:0] r;
    for (int i = 0; i < N; i++) r[i*CW +: CW] = eg[i];
    return r;
  endfunction

  task automatic apply();
    bus.s_valid = vld;
    for (int i = 0; i < N; i++) bus.s_data[i*W +: W] = src_data[i];
  endtask

  task automatic tick();
    int   w;
    logic mr;
    w  = pick();
    mr = bus.m_ready;
    @(posedge clk);
`ifdef DEPTH_EVENT_ARB_STATS_EN
    if (rst || stats_clr) begin
      for (int i = 0; i < N; i++) eg[i] = '0;
      es = '0;
    end else begin
      if (w >= 0) eg[w] = eg[w] + 1;
      if (mv && !mr) es = es + 1;
    end
`endif
    if (w >= 0) begin
      for (int i = 0; i < N; i++) if (i != w && vld[i]) waits[i]++;
      waits[w] = 0;
    end
    if (rst) begin
      mv = 1'b0; md = '0; ms = 0; ml = N - 1;
    end else if (w >= 0) begin
      mv = 1'b1; md = src_data[w]; ms = w; ml = w;
    end else if (!mv || mr) begin
      mv = 1'b0;
    end
    if (w >= 0) begin
      src_data[w] = rand_rec();
      if (rand_src) vld[w] = 1'($urandom_range(0, 1));
    end
    if (rand_src) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i] = 1'b1;
          src_data[i] = rand_rec();
          waits[i] = 0;
        end
      end
    end
    #1;
    apply();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rand_src = 1'b0;
    stats_clr = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) waits[i] = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.m_ready = 1'b1;
    vld = '1;
    for (int i = 0; i < N; i++) src_data[i] = rand_rec();
    apply();
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++;
      if (bus.m_valid !== 1'b0 || bus.m_src !== SW'(0) || bus.m_valid !== mv)
        $display("FAIL reset_out cyc=%0d m_valid=%b m_src=%0d exp 0/0", k, bus.m_valid, bus.m_src);
      else pass_cnt++;
      #2;
      total_cnt++;
      if (bus.s_ready !== 4'b0000)
        $display("FAIL reset_ready cyc=%0d got=%b exp=0000", k, bus.s_ready);
      else pass_cnt++;
    end
    rst = 1'b0;
    #2;
    total_cnt++;
    if (bus.s_ready !== 4'b0001 || bus.s_ready !== onehot(pick()))
      $display("FAIL reset_first_ready got=%b exp=0001", bus.s_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.m_valid !== 1'b1 || bus.m_src !== SW'(0) || bus.m_data !== md)
      $display("FAIL reset_first_grant v=%b src=%0d data=%h exp v=1 src=0 data=%h",
               bus.m_valid, bus.m_src, bus.m_data, md);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    do_reset();
    vld = '1;
    apply();
    for (int k = 0; k < 8; k++) begin
      #2;
      total_cnt++;
      if (bus.s_ready !== onehot(k % N))
        $display("FAIL fair_ready cyc=%0d got=%b exp=%b", k, bus.s_ready, onehot(k % N));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.m_valid !== 1'b1 || bus.m_src !== SW'(k % N) || bus.m_data !== md)
        $display("FAIL fair_out cyc=%0d v=%b src=%0d exp v=1 src=%0d", k, bus.m_valid, bus.m_src, k % N);
      else pass_cnt++;
    end
  endtask

  task automatic test_sparse();
    int e;
    do_reset();
    vld = 4'b1010;
    apply();
    for (int k = 0; k < 8; k++) begin
      e = (k % 2 == 0) ? 1 : 3;
      #2;
      total_cnt++;
      if (bus.s_ready !== onehot(e) || bus.s_ready[0] !== 1'b0 || bus.s_ready[2] !== 1'b0)
        $display("FAIL sparse_ready cyc=%0d got=%b exp=%b", k, bus.s_ready, onehot(e));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.m_valid !== 1'b1 || bus.m_src !== SW'(e) || bus.m_data !== md)
        $display("FAIL sparse_out cyc=%0d src=%0d exp=%0d", k, bus.m_src, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    vld = 4'b0101;
    apply();
    tick();
    total_cnt++;
    if (bus.m_src !== SW'(0) || bus.m_valid !== 1'b1)
      $display("FAIL wrap_first src=%0d v=%b exp src=0 v=1", bus.m_src, bus.m_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.m_src !== SW'(2) || bus.m_data !== md)
      $display("FAIL wrap_second src=%0d exp=2", bus.m_src);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] stall_base;
    do_reset();
    vld = '1;
    apply();
    tick();
    bus.m_ready = 1'b0;
    stall_base = es;
    for (int k = 0; k < 5; k++) begin
      #2;
      total_cnt++;
      if (bus.s_ready !== 4'b0000)
        $display("FAIL bp_ready cyc=%0d got=%b exp=0000", k, bus.s_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.m_valid !== 1'b1 || bus.m_src !== SW'(0) || bus.m_data !== md)
        $display("FAIL bp_hold cyc=%0d v=%b src=%0d exp v=1 src=0", k, bus.m_valid, bus.m_src);
      else pass_cnt++;
    end
    total_cnt++;
`ifdef DEPTH_EVENT_ARB_STATS_EN
    if (stall_cnt !== es || es !== stall_base + 5)
`else
    if (stall_cnt !== es || stall_cnt !== '0)
`endif
      $display("FAIL bp_stall_cnt got=%0d exp=%0d", stall_cnt, es);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    #2;
    total_cnt++;
    if (bus.s_ready !== 4'b0000)
      $display("FAIL midrst_ready got=%b exp=0000", bus.s_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.m_valid !== 1'b0 || bus.m_src !== SW'(0) || bus.m_data !== '0 ||
        stall_cnt !== '0 || grant_cnt !== '0)
      $display("FAIL midrst_out v=%b src=%0d data=%h stall=%0d exp all 0",
               bus.m_valid, bus.m_src, bus.m_data, stall_cnt);
    else pass_cnt++;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    #2;
    total_cnt++;
    if (bus.s_ready !== 4'b0001)
      $display("FAIL midrst_first got=%b exp=0001", bus.s_ready);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_stats();
    do_reset();
    vld = 4'b0100;
    apply();
    for (int k = 0; k < 10; k++) tick();
    total_cnt++;
`ifdef DEPTH_EVENT_ARB_STATS_EN
    if (grant_cnt[2*CW +: CW] !== 32'd10 || grant_cnt !== exp_gcnt())
`else
    if (grant_cnt !== '0 || grant_cnt !== exp_gcnt())
`endif
      $display("FAIL stats_grant2 got=%0d exp=%0d", grant_cnt[2*CW +: CW], eg[2]);
    else pass_cnt++;
    stats_clr = 1'b1;
    #2;
    total_cnt++;
    if (bus.s_ready !== 4'b0100)
      $display("FAIL stats_clr_grant got=%b exp=0100", bus.s_ready);
    else pass_cnt++;
    tick();
    stats_clr = 1'b0;
    total_cnt++;
    if (grant_cnt[2*CW +: CW] !== '0 || grant_cnt !== exp_gcnt() || stall_cnt !== es)
      $display("FAIL stats_clr got=%0d exp=0", grant_cnt[2*CW +: CW]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    rand_src = 1'b1;
    vld = '0;
    apply();
    for (int k = 0; k < 400; k++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      stats_clr = ($urandom_range(0, 49) == 0);
      #2;
      total_cnt++;
      if (bus.s_ready !== onehot(pick()))
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", k, bus.s_ready, onehot(pick()));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.m_valid !== mv || (mv && (bus.m_src !== SW'(ms) || bus.m_data !== md)))
        $display("FAIL rand_out cyc=%0d v=%b src=%0d exp v=%b src=%0d", k, bus.m_valid, bus.m_src, mv, ms);
      else pass_cnt++;
      total_cnt++;
      if (grant_cnt !== exp_gcnt() || stall_cnt !== es)
        $display("FAIL rand_cnt cyc=%0d stall=%0d exp=%0d grant=%h exp=%h",
                 k, stall_cnt, es, grant_cnt, exp_gcnt());
      else pass_cnt++;
      for (int i = 0; i < N; i++) begin
        total_cnt++;
        if (waits[i] > N - 1)
          $display("FAIL rand_starve src=%0d waited=%0d max=%0d", i, waits[i], N - 1);
        else pass_cnt++;
      end
    end
    rand_src = 1'b0;
    stats_clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      eg[i] = '0;
      waits[i] = 0;
      src_data[i] = '0;
    end
    bus.m_ready = 1'b1;
    apply();
    test_reset();
    test_fairness();
    test_sparse();
    test_wrap();
    test_backpressure();
    test_mid_reset();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
